// File: rtl/serial_frame_pkg.sv
// Shared types and default constants for the serial frame deserializer.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        PARITY
    } state_e;

    localparam int unsigned   DEF_WIDTH    = 8;
    localparam int unsigned   DEF_SYNC_LEN = 4;
    localparam logic [3:0]    DEF_SYNC_PAT = 4'b1011;
    localparam int unsigned   DROP_CNT_W   = 8;

endpackage

// File: rtl/serial_frame_deser_if.sv
// Serial input, valid/ready word output and status bundle of the deserializer.
interface serial_frame_deser_if
    import serial_frame_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic                  bit_in;
    logic                  bit_en;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  parity_err;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_cnt;
    logic                  busy;

    modport master (
        output bit_in, bit_en, out_ready,
        input  out_data, out_valid, parity_err, overflow, drop_cnt, busy
    );

    modport slave (
        input  bit_in, bit_en, out_ready,
        output out_data, out_valid, parity_err, overflow, drop_cnt, busy
    );

endinterface

// File: rtl/frame_sync_match.sv
// Sliding sync-pattern window; match is combinational and includes the incoming bit.
module frame_sync_match #(
    parameter int unsigned          SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0]  SYNC_PAT = 4'b1011
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bit,
    input  logic i_en,
    input  logic i_clear,
    output logic o_match
);

    logic [SYNC_LEN-1:0] r_win;
    logic [SYNC_LEN-1:0] w_next;

    assign w_next  = {r_win[SYNC_LEN-2:0], i_bit};
    assign o_match = i_en && (w_next == SYNC_PAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (i_clear) begin
            r_win <= '0;
        end else if (i_en) begin
            r_win <= w_next;
        end
    end

endmodule

// File: rtl/serial_frame_deser.sv
// Sync hunt, MSB-first word assembly, parity check and single-entry output slot.
module serial_frame_deser
    import serial_frame_pkg::*;
#(
    parameter int unsigned          WIDTH      = DEF_WIDTH,
    parameter int unsigned          SYNC_LEN   = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0]  SYNC_PAT   = DEF_SYNC_PAT,
    parameter bit                   ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_frame_deser_if.slave  io_bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [WIDTH-1:0]      r_data;
    logic [WIDTH-1:0]      r_out_data;
    logic                  r_out_valid;
    logic                  r_parity_err;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  r_busy;

    logic w_match;
    logic w_hunt_en;
    logic w_clear;
    logic w_par;
    logic w_good;
    logic w_slot_free;

    assign w_hunt_en   = io_bus.bit_en && (r_state == HUNT);
    // Window is wiped as each frame ends so a new frame needs a fresh sync.
    assign w_clear     = io_bus.bit_en && (r_state == PARITY);
    assign w_par       = ^{r_data, io_bus.bit_in};
    assign w_good      = (w_par == ODD_PARITY);
    assign w_slot_free = !r_out_valid || io_bus.out_ready;

    frame_sync_match #(
        .SYNC_LEN (SYNC_LEN),
        .SYNC_PAT (SYNC_PAT)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_bit   (io_bus.bit_in),
        .i_en    (w_hunt_en),
        .i_clear (w_clear),
        .o_match (w_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= HUNT;
            r_cnt        <= '0;
            r_data       <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            r_overflow   <= 1'b0;
            if (r_out_valid && io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (io_bus.bit_en) begin
                case (r_state)
                    HUNT: begin
                        if (w_match) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_data <= {r_data[WIDTH-2:0], io_bus.bit_in};
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(WIDTH - 1)) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        if (!w_good) begin
                            r_parity_err <= 1'b1;
                        end else if (w_slot_free) begin
                            r_out_data  <= r_data;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                            if (r_drop_cnt != '1) begin
                                r_drop_cnt <= r_drop_cnt + 1'b1;
                            end
                        end
                        r_state <= HUNT;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= HUNT;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_bus.out_data   = r_out_data;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.parity_err = r_parity_err;
    assign io_bus.overflow   = r_overflow;
    assign io_bus.drop_cnt   = r_drop_cnt;
    assign io_bus.busy       = r_busy;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Scenario bench for serial_frame_deser with a scoreboard on accepted words.
module tb_serial_frame_deser;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_frame_deser_if bus ();

    serial_frame_deser dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [7:0] exp_w;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_acc   = 0;

    // Scoreboard: a word is consumed on the next edge whenever valid&&ready is seen here.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_tests++;
            n_acc++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL accept_unexpected: got %h, expected no word", bus.out_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (bus.out_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL accept_data: got %h, expected %h", bus.out_data, exp_w);
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        bus.bit_in = b;
        bus.bit_en = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_en = 1'b0;
        bus.bit_in = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.bit_en = 1'b0;
        bus.bit_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            if (gap) idle_cycle();
            drive_bit(v[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input bit gap);
        send_bits(16'b1011, 4, gap);
        send_bits({8'h00, d}, 8, gap);
        if (gap) idle_cycle();
        drive_bit(p);
    endtask

    task automatic test_reset();
        bus.bit_in    = 1'b0;
        bus.bit_en    = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.out_data, bus.out_valid, bus.parity_err, bus.overflow, bus.drop_cnt, bus.busy}
            !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h valid=%b busy=%b drop=%0d, expected all 0",
                     bus.out_data, bus.out_valid, bus.busy, bus.drop_cnt);
        end
        rst = 1'b0;
        // Fill the slot, then enter DATA so both busy and out_valid are high.
        send_frame(8'hA5, 1'b0, 1'b0);
        send_bits(16'b1011, 4, 1'b0);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got busy=%b valid=%b, expected 1 1", bus.busy, bus.out_valid);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.out_data, bus.out_valid, bus.parity_err, bus.overflow, bus.drop_cnt, bus.busy}
            !== 20'h0) begin
            n_fail++;
            $display("FAIL async_reset: got data=%h valid=%b busy=%b, expected all 0",
                     bus.out_data, bus.out_valid, bus.busy);
        end
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        idle_cycle();
    endtask

    task automatic test_good_frame();
        bus.out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL good_frame: got valid=%b data=%h perr=%b, expected 1 a5 0",
                     bus.out_valid, bus.out_data, bus.parity_err);
        end
        idle_cycle();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_frame_one_cycle: got valid=%b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_bad_parity();
        bus.out_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        n_tests++;
        if (bus.parity_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_parity: got perr=%b valid=%b busy=%b ovf=%b, expected 1 0 0 0",
                     bus.parity_err, bus.out_valid, bus.busy, bus.overflow);
        end
        idle_cycle();
        n_tests++;
        if (bus.parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_parity_pulse: got perr=%b, expected 0", bus.parity_err);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        n_tests++;
        if (bus.overflow !== 1'b1 || bus.out_data !== 8'hA5 || bus.drop_cnt !== 8'd1 ||
            bus.parity_err !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got ovf=%b data=%h drop=%0d perr=%b valid=%b, expected 1 a5 1 0 1",
                     bus.overflow, bus.out_data, bus.drop_cnt, bus.parity_err, bus.out_valid);
        end
        idle_cycle();
        n_tests++;
        if (bus.overflow !== 1'b0 || bus.out_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL overflow_pulse: got ovf=%b data=%h, expected 0 a5",
                     bus.overflow, bus.out_data);
        end
        bus.out_ready = 1'b1;
        idle_cycle();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got valid=%b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_bit_en_gaps();
        bus.out_ready = 1'b1;
        send_bits(16'b10101, 5, 1'b1);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early_sync: got busy=%b after 5 bits, expected 0", bus.busy);
        end
        send_bits(16'b1, 1, 1'b1);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_6th: got busy=%b after 6 bits, expected 1", bus.busy);
        end
        exp_q.push_back(8'h3C);
        send_bits(16'h003C, 8, 1'b1);
        idle_cycle();
        drive_bit(1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL gap_frame: got valid=%b data=%h, expected 1 3c",
                     bus.out_valid, bus.out_data);
        end
        idle_cycle();
    endtask

    task automatic test_reset_midframe();
        int acc0;
        bus.out_ready = 1'b1;
        send_bits(16'b1011, 4, 1'b0);
        send_bits(16'b1010, 4, 1'b0);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got busy=%b drop=%0d, expected 0 0",
                     bus.busy, bus.drop_cnt);
        end
        acc0 = n_acc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.parity_err !== 1'b0 ||
            bus.drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL post_reset_frame: got valid=%b data=%h perr=%b drop=%0d, expected 1 a5 0 0",
                     bus.out_valid, bus.out_data, bus.parity_err, bus.drop_cnt);
        end
        repeat (3) idle_cycle();
        n_tests++;
        if (n_acc - acc0 !== 1) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d words, expected 1", n_acc - acc0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_backpressure();
        test_bit_en_gaps();
        test_reset_midframe();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending words, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
